// File: rtl/hgcal_in_pkg.sv
// Shared types and constants for the HGCAL autoencoder input quantizer.
// Activation codes, FSM states, default thresholds and counter sizing.
package hgcal_in_pkg;

  typedef logic [1:0] code_t;

  localparam code_t CODE_00 = 2'b00;
  localparam code_t CODE_01 = 2'b01;
  localparam code_t CODE_10 = 2'b10;
  localparam code_t CODE_11 = 2'b11;

  typedef enum logic {
    FILL   = 1'b0,
    RESYNC = 1'b1
  } state_t;

  localparam int T0_DEF = -32;
  localparam int T1_DEF = 0;
  localparam int T2_DEF = 32;

  // Channel index width; never narrower than one bit.
  function automatic int idx_w(input int n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/hgcal_quant2.sv
// Combinational three-threshold comparator mapping a signed sample to a
// 2-bit activation code.
module hgcal_quant2
  import hgcal_in_pkg::*;
#(
  parameter int                     IN_W = 8,
  parameter logic signed [IN_W-1:0] T0   = IN_W'(T0_DEF),
  parameter logic signed [IN_W-1:0] T1   = IN_W'(T1_DEF),
  parameter logic signed [IN_W-1:0] T2   = IN_W'(T2_DEF)
) (
  input  logic signed [IN_W-1:0] x,
  output code_t                  code
);

  always_comb begin
    code = CODE_11;
    if (x < T0) begin
      code = CODE_00;
    end else if (x < T1) begin
      code = CODE_01;
    end else if (x < T2) begin
      code = CODE_10;
    end
  end

endmodule

// File: rtl/hgcal_input_quantizer.sv
// Streaming quantizer packing N_CH 2-bit codes per frame, with one frame in
// assembly and one on output so input stalls only when both are occupied.
//
// state  | meaning
// FILL   | assembling a frame; idx selects the slot for the next sample
// RESYNC | after an over-long frame, dropping samples up to the next s_last
module hgcal_input_quantizer
  import hgcal_in_pkg::*;
#(
  parameter int                     IN_W = 8,
  parameter int                     N_CH = 48,
  parameter logic signed [IN_W-1:0] T0   = IN_W'(T0_DEF),
  parameter logic signed [IN_W-1:0] T1   = IN_W'(T1_DEF),
  parameter logic signed [IN_W-1:0] T2   = IN_W'(T2_DEF)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [IN_W-1:0] s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [2*N_CH-1:0]      m_data,
  output logic                   frame_err
);

  localparam int IDX_W = idx_w(N_CH);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [2*N_CH-1:0] asm_q, asm_d;
  logic              asm_full_q, asm_full_d;
  logic [2*N_CH-1:0] out_q, out_d;
  logic              m_valid_q, m_valid_d;
  logic              frame_err_q, frame_err_d;

  code_t             code;
  logic [2*N_CH-1:0] asm_wr;
  logic              accept;
  logic              out_free;
  logic              idx_last;

  hgcal_quant2 #(
    .IN_W (IN_W),
    .T0   (T0),
    .T1   (T1),
    .T2   (T2)
  ) u_quant (
    .x    (s_data),
    .code (code)
  );

  assign s_ready  = !asm_full_q;
  assign accept   = s_valid && s_ready;
  assign out_free = !m_valid_q || m_ready;
  assign idx_last = (idx_q == IDX_W'(N_CH - 1));

  always_comb begin
    asm_wr = asm_q;
    asm_wr[{idx_q, 1'b0} +: 2] = code;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    asm_full_d  = asm_full_q;
    out_d       = out_q;
    m_valid_d   = m_valid_q && !m_ready;
    frame_err_d = 1'b0;

    // A held frame and a new accept are mutually exclusive: s_ready is low while asm_full.
    if (asm_full_q && out_free) begin
      out_d      = asm_q;
      m_valid_d  = 1'b1;
      asm_full_d = 1'b0;
    end

    if (accept) begin
      case (state_q)
        FILL: begin
          if (idx_last) begin
            idx_d = '0;
            if (s_last) begin
              if (out_free) begin
                out_d     = asm_wr;
                m_valid_d = 1'b1;
              end else begin
                asm_d      = asm_wr;
                asm_full_d = 1'b1;
              end
            end else begin
              frame_err_d = 1'b1;
              state_d     = RESYNC;
            end
          end else if (s_last) begin
            frame_err_d = 1'b1;
            idx_d       = '0;
          end else begin
            asm_d = asm_wr;
            idx_d = idx_q + IDX_W'(1);
          end
        end
        RESYNC: begin
          if (s_last) begin
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      asm_q       <= '0;
      asm_full_q  <= 1'b0;
      out_q       <= '0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      asm_full_q  <= asm_full_d;
      out_q       <= out_d;
      m_valid_q   <= m_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = out_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/hgcal_input_quantizer.md
# hgcal_input_quantizer

Streaming front-end that feeds the first LUT-neuron layer of the HGCAL autoencoder.
- Accepts one signed sensor sample per handshake and quantizes it to a 2-bit activation code.
- Packs N_CH codes into one frame word and presents it, with valid/ready, to the layer-1 neuron array, which slices its fan-in buses directly from the frame.
- Holds one frame in assembly and one on output (ping-pong), so input is only stalled when both are occupied.

## Interface
Parameters:
- IN_W, 8, width of a signed input sample
- N_CH, 48, samples (channels) per frame
- T0, -32, lowest threshold (signed, IN_W bits)
- T1, 0, middle threshold
- T2, 32, highest threshold; T0 < T1 < T2 is required

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- s_valid  in  1  input sample valid
- s_ready  out  1  block accepts sample this cycle
- s_data  in  IN_W  signed sample
- s_last  in  1  marks the final sample of a frame
- m_valid  out  1  frame word valid
- m_ready  in  1  downstream (layer-1 array plus its capture register) accepts
- m_data  out  2*N_CH  packed codes; channel i at bits [2i+1:2i]
- frame_err  out  1  one-cycle pulse when a malformed frame is dropped

## Operation
- Transfer occurs when valid && ready, on either side.
- Quantization of sample x (signed compare):
  - x < T0 -> 2'b00
  - T0 <= x < T1 -> 2'b01
  - T1 <= x < T2 -> 2'b10
  - x >= T2 -> 2'b11
- Channel index counter idx runs 0..N_CH-1, with width clog2(N_CH). Each accepted sample writes its code into the assembly register at slot idx.
- States:
  - FILL: normal assembly.
    - Accepted sample with idx == N_CH-1 and s_last = 1: frame complete, idx -> 0.
    - Accepted s_last with idx < N_CH-1 (short frame): discard assembly, pulse frame_err, idx -> 0, stay in FILL.
    - Accepted sample with idx == N_CH-1 and s_last = 0 (long frame): discard, pulse frame_err, go to RESYNC.
  - RESYNC: accepted samples are discarded (s_ready = 1). An accepted s_last returns to FILL with idx = 0 and no further frame_err.
- On frame complete:
  - If the output register is empty, or m_ready is high that cycle, the completed frame moves to the output register.
  - Otherwise it stays in assembly and sets asm_full.
- s_ready = !asm_full. While asm_full, the held frame moves to output on the first cycle the output register drains, and asm_full clears the same cycle.
- m_valid stays high and m_data stays stable until m_ready is seen.
- Reset values: state = FILL, idx = 0, asm_full = 0, m_valid = 0, m_data = 0, frame_err = 0, s_ready = 1 (combinational from asm_full).
- Reset during operation discards both the partial frame and any pending output frame. No frame_err is emitted for frames lost to reset.

## Timing
- Latency: last sample accepted at edge t -> m_valid high after edge t+1 (registered output), provided the output register is free.
- Sustained throughput is one sample per cycle. No bubble between frames while m_ready = 1.
- Simultaneous events:
  - A frame completes while the output register is being consumed in the same cycle: the new frame is loaded, m_valid stays high, and no asm_full is set.
  - With asm_full = 1 and m_ready = 1: the held frame moves to output, and s_ready rises the next cycle.
- frame_err asserts the cycle after the offending accept, for exactly one cycle.
- s_ready has no combinational path from m_ready. m_valid and m_data are register outputs.

## Structure
- Package hgcal_in_pkg holds:
  - code type (2 bits) and the encodings CODE_00..CODE_11
  - the state enum {FILL, RESYNC}
  - default thresholds
  - the function idx_w(N_CH)
- One sub-module: hgcal_quant2, a purely combinational threshold comparator with parameters T0..T2 and ports x -> code, instantiated once.
- The top level holds the counter, state register, assembly and output registers, and the handshake logic.

## Test plan
- Bench runs with N_CH=4, IN_W=8 and default thresholds.
- Basic frame: samples -40, -1, 0, 100 with s_last on the 4th sample, m_ready=1 -> m_data=8'b11_10_01_00 one cycle after the last accept; frame_err stays 0.
- Threshold edges: samples -33, -32, 31, 32 -> codes 00, 01, 10, 11, giving m_data = 8'b11_10_01_00.
- Back-pressure: m_ready=0 while three frames are streamed back-to-back.
  - Frame 1 is held on output and frame 2 in assembly.
  - s_ready drops after frame 2's last sample.
  - Raising m_ready delivers frames 1, 2, 3 in order, each unchanged.
- Short frame: s_last on the 2nd sample -> frame_err pulses once, no m_valid. The next well-formed frame outputs correctly.
- Long frame: 6 samples with s_last on the 6th -> frame_err pulses once after the 4th sample; samples 5–6 are dropped; the next frame is correct.
- Reset mid-frame: rst low after 2 samples with an output frame pending -> m_valid=0 and m_data=0 immediately; after release, a fresh 4-sample frame outputs correctly.
